// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the VGA sync generator to the
// character-position / font ROM stages and to the frame-rate logic.
interface vga_sync_gen_if;
  logic [9:0] Qh;        // horizontal pixel counter
  logic [9:0] Qv;        // vertical line counter
  logic       p_tick;    // pixel-rate enable
  logic       hsync;     // active-low horizontal sync
  logic       vsync;     // active-low vertical sync
  logic       video_on;  // visible-area flag
  logic       f_tick;    // one-cycle end-of-frame pulse

  modport master (output Qh, Qv, p_tick, hsync, vsync, video_on, f_tick);
  modport slave  (input  Qh, Qv, p_tick, hsync, vsync, video_on, f_tick);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider, horizontal/vertical counters, sync and
// blanking flags, and an end-of-frame pulse for the VGA text path.
// Optional macro VGA_SYNC_DELAY_EN: delays hsync/vsync/video_on by two reloj
// cycles so they line up with the font ROM address and data registers.
module vga_sync_gen #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic           reloj,
  input  logic           resetM,
  vga_sync_gen_if.master vga_o
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_flags_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       qh_q, qh_d;
  logic [9:0]       qv_q, qv_d;
  logic             p_tick;
  logic             frame_wrap;
  logic             f_tick_q;
  sync_flags_t      flags_q, flags_d;
  sync_flags_t      flags_out;

  assign p_tick = (div_q == DIV_LAST);

  // Next-state counters, and flags decoded from the next-state counters so
  // the registered flags always describe the Qh/Qv being presented.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    div_d      = p_tick ? '0 : div_q + DIV_ONE;
    qh_d       = qh_q;
    qv_d       = qv_q;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (qh_q == H_LAST) begin
        qh_d = '0;
        if (qv_q == V_LAST) begin
          qv_d       = '0;
          frame_wrap = 1'b1;
        end else begin
          qv_d = qv_q + 10'd1;
        end
      end else begin
        qh_d = qh_q + 10'd1;
      end
    end
    flags_d.hsync    = !((qh_d >= HS_FIRST) && (qh_d <= HS_LAST));
    flags_d.vsync    = !((qv_d >= VS_FIRST) && (qv_d <= VS_LAST));
    flags_d.video_on = (qh_d < H_VIS) && (qv_d < V_VIS);
  end

  // Timing state register; reset wins over any wrap, so f_tick stays low.
  always_ff @(posedge reloj) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (resetM) begin
      div_q    <= '0;
      qh_q     <= '0;
      qv_q     <= '0;
      flags_q  <= '1;
      f_tick_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      qh_q     <= qh_d;
      qv_q     <= qv_d;
      flags_q  <= flags_d;
      f_tick_q <= frame_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  sync_flags_t dly1_q, dly2_q;

  // Two-stage flag delay matching the font ROM address and data registers.
  always_ff @(posedge reloj) begin
    // NOTE: the delay stages are reset too, so sync stays inactive until real values arrive.
    if (resetM) begin
      dly1_q <= '1;
      dly2_q <= '1;
    end else begin
      dly1_q <= flags_q;
      dly2_q <= dly1_q;
    end
  end

  assign flags_out = dly2_q;
`else
  assign flags_out = flags_q;
`endif

  assign vga_o.Qh       = qh_q;
  assign vga_o.Qv       = qv_q;
  assign vga_o.p_tick   = p_tick;
  assign vga_o.hsync    = flags_out.hsync;
  assign vga_o.vsync    = flags_out.vsync;
  assign vga_o.video_on = flags_out.video_on;
  assign vga_o.f_tick   = f_tick_q;

endmodule
